// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Holds the program counter and fetches 32-bit instruction words from
//   instruction memory over a req/ack handshake. It splits each word into
//   decoder fields and presents them downstream over a valid/ready handshake.
//   When the downstream stage accepts an instruction, the next PC is chosen
//   by pcsel.
//
//   Optional feature macro: IFU_ILLOP_TRAP_EN
//     defined   : illop flags unimplemented opcodes while the instruction is
//                 presented. Accepting a flagged instruction forces the next
//                 PC to ILLOP_VECTOR.
//     undefined : illop is tied to 0, and pcsel alone selects the next PC.
//
// Ports
//   clk          in   1   clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   imem_req     out  1   fetch request, held until imem_ack
//   imem_addr    out  32  fetch address (word aligned, stable during req)
//   imem_ack     in   1   memory accepted the request; imem_rdata is valid
//   imem_rdata   in   32  instruction word
//   instr_valid  out  1   decoded fields are valid
//   instr_ready  in   1   downstream accepts the presented instruction
//   opcode       out  6   instr[31:26]
//   rc/ra/rb     out  5   instr[25:21] / [20:16] / [15:11]
//   literal      out  16  instr[15:0]
//   pc_plus4     out  32  address of the presented instruction + 4
//   pcsel        in   3   next-PC select, sampled on accept
//   jt           in   32  jump target for pcsel = 3'b010
//   illop        out  1   presented opcode is unimplemented
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] ILLOP_VECTOR = 32'h0000_0004,
   parameter logic [31:0] XADR_VECTOR  = 32'h0000_0008
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [5:0]  opcode,
   output logic [4:0]  rc,
   output logic [4:0]  ra,
   output logic [4:0]  rb,
   output logic [15:0] literal,
   output logic [31:0] pc_plus4,
   input  logic [2:0]  pcsel,
   input  logic [31:0] jt,
   output logic        illop
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] br_off;
   logic [31:0] target;
   logic [31:0] next_pc;
   logic        accept;

   // The PC register addresses memory directly, so the address stays stable
   // for the whole request.
   assign imem_addr = pc;

   assign opcode  = instr[31:26];
   assign rc      = instr[25:21];
   assign ra      = instr[20:16];
   assign rb      = instr[15:11];
   assign literal = instr[15:0];

   assign accept = (state == HOLD) && instr_ready;

   // The branch offset is a sign-extended word offset, relative to PC+4.
   assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

   // NOTE: every signal driven in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      target = pc_plus4;
      case (pcsel)
         3'b001:  target = pc_plus4 + br_off;
         3'b010:  target = jt;
         3'b011:  target = ILLOP_VECTOR;
         3'b100:  target = XADR_VECTOR;
         default: target = pc_plus4;
      endcase
`ifdef IFU_ILLOP_TRAP_EN
      // A trapped opcode overrides whatever the decoder drives on pcsel.
      if (illop) target = ILLOP_VECTOR;
`endif
      next_pc = target & ~32'h3;
   end

   // NOTE: sequential state uses non-blocking assignments only. Every
   // register reads the pre-edge value of every other register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         pc          <= RESET_VECTOR;
         instr       <= '0;
         pc_plus4    <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               imem_req <= 1'b1;
               state    <= FETCH;
            end
            FETCH: begin
               // Qualifying with the FETCH state ignores any ack that arrives
               // while no request is outstanding.
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  pc_plus4    <= pc + 32'd4;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  pc          <= next_pc;
                  imem_req    <= 1'b1;
                  instr_valid <= 1'b0;
                  state       <= FETCH;
               end
            end
            default: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

`ifdef IFU_ILLOP_TRAP_EN
   function automatic logic is_unimpl(input logic [5:0] op);
      is_unimpl = (op <= 6'h17) ||
                  (op inside {6'h1A, 6'h1C, 6'h27, 6'h2B, 6'h2F, 6'h37, 6'h3B, 6'h3F});
   endfunction

   logic illop_q;

   // The flag is captured with the word, so it is valid exactly while the
   // instruction is presented.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         illop_q <= 1'b0;
      end else if ((state == FETCH) && imem_ack) begin
         illop_q <= is_unimpl(imem_rdata[31:26]);
      end else if (accept) begin
         illop_q <= 1'b0;
      end
   end

   assign illop = illop_q;
`else
   assign illop = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. It acts as both the instruction
//   memory and the downstream decoder.
//
//   A table of fetch/accept records walks the PC through the following cases:
//     - sequential flow
//     - branch and jump targets
//     - the trap and interrupt vectors
//     - an out-of-range pcsel value
//     - the 32-bit wrap
//     - the illegal-op trap
//   Hand-written sequences cover reset in the FETCH state and in the HOLD
//   state.
//
//   Expected illop behaviour follows IFU_ILLOP_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

`ifdef IFU_ILLOP_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [5:0]  opcode;
   logic [4:0]  rc, ra, rb;
   logic [15:0] literal;
   logic [31:0] pc_plus4;
   logic [2:0]  pcsel;
   logic [31:0] jt;
   logic        illop;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .rc          (rc),
      .ra          (ra),
      .rb          (rb),
      .literal     (literal),
      .pc_plus4    (pc_plus4),
      .pcsel       (pcsel),
      .jt          (jt),
      .illop       (illop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic [2:0]  pcsel;
      logic [31:0] jt;
      int          ack_delay;
      int          stall;
      logic [5:0]  op;
      logic [4:0]  rc;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [15:0] lit;
      logic [31:0] pcp4;
      logic        illop;
      logic [31:0] next;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(
      input logic [31:0] addr, input logic [31:0] rdata, input logic [2:0] sel,
      input logic [31:0] jtv, input int ack_delay, input int stall,
      input logic [5:0] op, input logic [4:0] rcv, input logic [4:0] rav,
      input logic [4:0] rbv, input logic [15:0] lit, input logic [31:0] pcp4,
      input logic ill, input logic [31:0] next);
      vec_t v;
      v.addr = addr; v.rdata = rdata; v.pcsel = sel; v.jt = jtv;
      v.ack_delay = ack_delay; v.stall = stall;
      v.op = op; v.rc = rcv; v.ra = rav; v.rb = rbv; v.lit = lit;
      v.pcp4 = pcp4; v.illop = ill; v.next = next;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full instruction: wait for the request, answer it, observe the
   // presented fields, optionally stall, then accept and check the next fetch.
   task automatic run_vec(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("v%0d", idx);
      for (int k = 0; k < 20 && !imem_req; k++) begin
         @(posedge clk); #1;
      end
      check({tag, "_req"}, 32'(imem_req), 32'd1);
      check({tag, "_addr"}, imem_addr, v.addr);
      for (int k = 0; k < v.ack_delay; k++) begin
         @(posedge clk); #1;
         check({tag, "_req_held"}, {imem_req, imem_addr[30:0]}, {1'b1, v.addr[30:0]});
      end
      imem_ack   = 1'b1;
      imem_rdata = v.rdata;
      @(posedge clk); #1;
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      check({tag, "_valid"}, 32'(instr_valid), 32'd1);
      check({tag, "_req_off"}, 32'(imem_req), 32'd0);
      check({tag, "_fields"}, {opcode, rc, ra, rb, 11'd0}, {v.op, v.rc, v.ra, v.rb, 11'd0});
      check({tag, "_literal"}, 32'(literal), 32'(v.lit));
      check({tag, "_pc_plus4"}, pc_plus4, v.pcp4);
      check({tag, "_illop"}, 32'(illop), 32'(v.illop));
      // Backpressure, with a stray ack that must not be taken.
      for (int k = 0; k < v.stall; k++) begin
         instr_ready = 1'b0;
         imem_ack    = 1'b1;
         imem_rdata  = 32'hFFFF_FFFF;
         @(posedge clk); #1;
         check({tag, "_stall_vr"}, {30'd0, instr_valid, imem_req}, 32'b10);
         check({tag, "_stall_fields"}, {opcode, 10'd0, literal}, {v.op, 10'd0, v.lit});
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      pcsel       = v.pcsel;
      jt          = v.jt;
      @(posedge clk); #1;
      instr_ready = 1'b0;
      pcsel       = 3'b000;
      jt          = 32'h0;
      check({tag, "_next_vr"}, {30'd0, instr_valid, imem_req}, 32'b01);
      check({tag, "_next_addr"}, imem_addr, v.next);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(32'h0,         32'h8022_0800, 3'd0, 32'h0,         0, 5, 6'h20, 5'd1, 5'd2, 5'd1,  16'h0800, 32'h4,   1'b0, 32'h4);
      vecs[1]  = mk(32'h4,         32'h6C00_0000, 3'd2, 32'h203,       2, 0, 6'h1B, 5'd0, 5'd0, 5'd0,  16'h0000, 32'h8,   1'b0, 32'h200);
      vecs[2]  = mk(32'h200,       32'h6C00_0000, 3'd2, 32'h101,       0, 0, 6'h1B, 5'd0, 5'd0, 5'd0,  16'h0000, 32'h204, 1'b0, 32'h100);
      vecs[3]  = mk(32'h100,       32'h7400_FFFE, 3'd1, 32'h0,         1, 1, 6'h1D, 5'd0, 5'd0, 5'd31, 16'hFFFE, 32'h104, 1'b0, 32'hFC);
      vecs[4]  = mk(32'hFC,        32'h8022_0800, 3'd3, 32'h0,         0, 0, 6'h20, 5'd1, 5'd2, 5'd1,  16'h0800, 32'h100, 1'b0, 32'h4);
      vecs[5]  = mk(32'h4,         32'h6C00_0000, 3'd4, 32'h0,         0, 0, 6'h1B, 5'd0, 5'd0, 5'd0,  16'h0000, 32'h8,   1'b0, 32'h8);
      vecs[6]  = mk(32'h8,         32'h6C00_0000, 3'd7, 32'hFFFF_FFF0, 0, 0, 6'h1B, 5'd0, 5'd0, 5'd0,  16'h0000, 32'hC,   1'b0, 32'hC);
      vecs[7]  = mk(32'hC,         32'h6C00_0000, 3'd2, 32'hFFFF_FFFF, 0, 0, 6'h1B, 5'd0, 5'd0, 5'd0,  16'h0000, 32'h10,  1'b0, 32'hFFFF_FFFC);
      vecs[8]  = mk(32'hFFFF_FFFC, 32'h8022_0800, 3'd0, 32'h0,         0, 2, 6'h20, 5'd1, 5'd2, 5'd1,  16'h0800, 32'h0,   1'b0, 32'h0);
      vecs[9]  = mk(32'h0,         32'h8022_0800, 3'd4, 32'h0,         0, 0, 6'h20, 5'd1, 5'd2, 5'd1,  16'h0800, 32'h4,   1'b0, 32'h8);
      vecs[10] = mk(32'h8,         32'h6800_0000, 3'd0, 32'h0,         0, 2, 6'h1A, 5'd0, 5'd0, 5'd0,  16'h0000, 32'hC,   TRAP,
                    TRAP ? 32'h4 : 32'hC);
      vecs[11] = mk(TRAP ? 32'h4 : 32'hC, 32'h8022_0800, 3'd0, 32'h0,  0, 0, 6'h20, 5'd1, 5'd2, 5'd1,  16'h0800,
                    TRAP ? 32'h8 : 32'h10, 1'b0, TRAP ? 32'h8 : 32'h10);
      vecs[12] = mk(TRAP ? 32'h8 : 32'h10, 32'h7400_0003, 3'd1, 32'h0, 0, 0, 6'h1D, 5'd0, 5'd0, 5'd0,  16'h0003,
                    TRAP ? 32'hC : 32'h14, 1'b0, TRAP ? 32'h18 : 32'h20);

      reset_n     = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      instr_ready = 1'b0;
      pcsel       = 3'b000;
      jt          = 32'h0;

      // Reset values.
      #12;
      check("rst_vr", {30'd0, instr_valid, imem_req}, 32'b00);
      check("rst_fields", {opcode, rc, ra, rb, 11'd0}, 32'h0);
      check("rst_misc", {15'd0, illop, literal}, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h0);

      // Release, then reset asynchronously in the middle of FETCH.
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_addr", imem_addr, 32'h0);
      #2 reset_n = 1'b0;
      #1;
      check("rst_fetch_vr", {30'd0, instr_valid, imem_req}, 32'b00);

      // Reset while an instruction is held.
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h8022_0800;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      check("hold_valid", 32'(instr_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_hold_vr", {30'd0, instr_valid, imem_req}, 32'b00);
      check("rst_hold_fields", {opcode, 10'd0, literal}, 32'h0);
      check("rst_hold_pc_plus4", pc_plus4, 32'h0);

      // The first fetch after release goes to the reset vector.
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         run_vec(i, vecs[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
